// File: rtl/mio_mem_responder_if.sv
// CPU-side memory/IO request bus for mio_mem_responder.
// master = CPU initiator, slave = responder.
interface mio_mem_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        MIO_ready;
    logic        err;

    modport master (
        output CPU_MIO, mem_w, Addr_in, Data_in,
        input  Data_out, MIO_ready, err
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_in, Data_in,
        output Data_out, MIO_ready, err
    );
endinterface

// File: rtl/mio_mem_responder.sv
// Wait-stated RAM responder with optional LED/switch I/O window.
// Define MIO_IO_REGION_EN to decode the 0xE I/O region.
module mio_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mio_mem_responder_if.slave   bus,
    input  logic [15:0]          sw_in,
    output logic [15:0]          led_out
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    logic                  is_idle;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_data;
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  ram_hit;
    logic                  led_hit;
    logic                  sw_hit;
    logic                  unmapped;
    logic                  enter_ack;
    logic                  mem_we;
    logic [31:0]           io_rd;
    logic [31:0]           rd_word;
    logic                  unused_lsb;

    // With zero wait states the ACK-entry edge is the request edge itself,
    // so decode straight from the bus while idle, else from the latch.
    assign is_idle  = (state_q == IDLE);
    assign cur_addr = is_idle ? bus.Addr_in : addr_q;
    assign cur_data = is_idle ? bus.Data_in : wdata_q;
    assign cur_we   = is_idle ? bus.mem_w   : we_q;

    assign idx        = cur_addr[ADDR_WIDTH+1:2];
    assign ram_hit    = (cur_addr[31:ADDR_WIDTH+2] == '0);
    assign unmapped   = !(ram_hit || led_hit || sw_hit);
    assign unused_lsb = ^cur_addr[1:0];

    assign enter_ack = (is_idle && bus.CPU_MIO && (WAIT_N == 4'd0))
                    || ((state_q == WAIT) && (cnt_q == WAIT_N));
    assign mem_we    = rst && enter_ack && cur_we && ram_hit;

    assign rd_word = ram_hit ? mem_q[idx] : io_rd;

`ifdef MIO_IO_REGION_EN
    logic [15:0] led_q;

    assign led_hit = (cur_addr[31:28] == 4'hE) && (cur_addr[27:2] == 26'h0);
    assign sw_hit  = (cur_addr[31:28] == 4'hE) && (cur_addr[27:2] == 26'h1);
    assign io_rd   = led_hit ? {16'h0, led_q}
                   : sw_hit  ? {16'h0, sw_in} : 32'h0;
    assign led_out = led_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q <= 16'h0;
        end else if (enter_ack && cur_we && led_hit) begin
            led_q <= cur_data[15:0];
        end
    end
`else
    logic unused_sw;

    assign led_hit   = 1'b0;
    assign sw_hit    = 1'b0;
    assign io_rd     = 32'h0;
    assign led_out   = 16'h0;
    assign unused_sw = ^sw_in;
`endif

    // RAM is deliberately not reset; mem_we is gated by rst instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= cur_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.CPU_MIO) begin
                        addr_q  <= bus.Addr_in;
                        wdata_q <= bus.Data_in;
                        we_q    <= bus.mem_w;
                        cnt_q   <= 4'd1;
                        state_q <= (WAIT_N == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == WAIT_N) begin
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
            if (enter_ack) begin
                ready_q <= 1'b1;
                err_q   <= unmapped;
                if (!cur_we) begin
                    rdata_q <= rd_word;
                end
            end
        end
    end

    assign bus.MIO_ready = ready_q;
    assign bus.err       = err_q;
    assign bus.Data_out  = rdata_q;
endmodule

// File: doc/mio_mem_responder.md
MIO_MEM_RESPONDER -- requirements
Module: mio_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address width of internal RAM (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before MIO_ready (legal range 0..15).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 CPU_MIO  input  1  request valid from CPU initiator.
REQ-007 mem_w  input  1  1 = write, 0 = read; sampled with request.
REQ-008 Addr_in  input  32  byte address; bits [1:0] ignored.
REQ-009 Data_in  input  32  write data from CPU.
REQ-010 Data_out  output  32  read data to CPU.
REQ-011 MIO_ready  output  1  one-cycle completion strobe.
REQ-012 err  output  1  unmapped-access flag, valid only with MIO_ready.
REQ-013 sw_in  input  16  switch inputs.
REQ-014 led_out  output  16  LED register.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, ACK.
REQ-016 IDLE, CPU_MIO=1 at edge E0: latch Addr_in, Data_in, mem_w; go to WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0).
REQ-017 WAIT: 4-bit counter SHALL count WAIT_CYCLES edges from E0, then enter ACK; MIO_ready high exactly in the cycle after edge E0+WAIT_CYCLES.
REQ-018 ACK: MIO_ready=1 for exactly one cycle, then unconditional return to IDLE.
REQ-019 Requests during WAIT/ACK SHALL be ignored; inputs changing or CPU_MIO deasserting mid-transaction SHALL not alter the latched transaction.
REQ-020 Back-to-back: CPU_MIO still high in IDLE after ACK SHALL start a new transaction (min one IDLE cycle between MIO_ready pulses).
REQ-021 RAM region: latched Addr[31:ADDR_WIDTH+2]==0; word index Addr[ADDR_WIDTH+1:2].
REQ-022 Writes SHALL commit to RAM/LED at the edge entering ACK; no earlier side effect.
REQ-023 Reads: Data_out SHALL be registered at the edge entering ACK and hold until the next ACK entry.
REQ-024 Read of a word written by the immediately preceding transaction SHALL return the new value.
REQ-025 Unmapped address: read returns 0x00000000, write dropped, err=1 with MIO_ready; otherwise err=0.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, counter 0, MIO_ready 0, err 0, Data_out 0, led_out 0.
REQ-027 Reset mid-transaction SHALL abort it with no RAM/LED write and no MIO_ready.
REQ-028 RAM contents SHALL not be reset.

Configuration
REQ-029 Macro MIO_IO_REGION_EN SHALL compile in the I/O region.
REQ-030 Defined: Addr[31:28]==4'hE decodes as I/O; offset 0x0 = LED register (R/W, bits[15:0], upper read bits 0); offset 0x4 = sw_in (read-only, zero-extended, writes dropped without err); other offsets unmapped.
REQ-031 Undefined: 0xE region unmapped per REQ-025; led_out tied to 0; sw_in unused.

Verification
REQ-032 WAIT_CYCLES=2, write 0x12345678 to 0x00000010 at E0 -> MIO_ready high only in cycle after E0+2, err=0; read 0x00000010 -> Data_out=0x12345678.
REQ-033 WAIT_CYCLES=0, read 0x00000004 then CPU_MIO held high -> MIO_ready in cycle after E0, next pulse exactly two cycles later.
REQ-034 Write 0xDEADBEEF to 0x00001000 (ADDR_WIDTH=8) -> err=1 with MIO_ready; read same -> 0x00000000, err=1; RAM word 0 unchanged.
REQ-035 MIO_IO_REGION_EN defined: write 0x0000A5A5 to 0xE0000000 -> led_out=0xA5A5 after ACK entry; sw_in=0x3C3C, read 0xE0000004 -> 0x00003C3C; undefined: same read -> 0, err=1.
REQ-036 Assert rst=0 in WAIT of a write to 0x00000020 -> MIO_ready never pulses, subsequent read of 0x00000020 returns prior value, all outputs 0 immediately.
